// File: rtl/eigen_pkg.sv
// eigen_pkg: ASCII constants, frame lengths, FSM encoding and hex helper for the eigen report UART
package eigen_pkg;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam int FRAME_LEN_BASE = 26;
  localparam int FRAME_LEN_SEED = 31;
`ifdef EIGEN_TX_SEED_EN
  localparam int FRAME_LEN = FRAME_LEN_SEED;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return n < 4'd10 ? ASCII_0 + {4'd0, n} : ASCII_A + {4'd0, n} - 8'd10;
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: valid/ready 8N1 byte serializer; ready rises in the last stop-bit cycle so bytes chain gaplessly
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       stop,
  output logic       txd
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic           active;
  logic [7:0]     shift;
  logic [3:0]     bit_cnt;
  logic [W-1:0]   baud_cnt;
  logic           last;
  assign last  = baud_cnt == W'(CLKS_PER_BIT - 1);
  assign stop  = active && bit_cnt == 4'd9;
  assign ready = !active || (stop && last);
  // bit_cnt 0 = start bit, 1..8 = data LSB first, 9 = stop bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      txd      <= 1'b1;
    end else if (valid && ready) begin
      active   <= 1'b1;
      shift    <= data;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      txd      <= 1'b0;
    end else if (active && last) begin
      baud_cnt <= '0;
      if (stop) begin
        active  <= 1'b0;
        bit_cnt <= '0;
        txd     <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        txd     <= bit_cnt == 4'd8 ? 1'b1 : shift[bit_cnt[2:0]];
      end
    end else if (active) begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/eigen_uart_tx.sv
// eigen_uart_tx: snapshots matrix/vector state and sends it as one ASCII hex report line; EIGEN_TX_SEED_EN adds the seed vector field
module eigen_uart_tx import eigen_pkg::*; #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] matrix_a,
  input  logic [15:0] vector_v,
  input  logic [15:0] v_new,
  input  logic [7:0]  iteration_count,
  output logic        uart_txd,
  output logic        busy,
  output logic        frame_done
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [4:0] LAST = 5'(FRAME_LEN);
  state_t      state;
  logic [4:0]  idx;
  logic [63:0] snap_m;
  logic [15:0] snap_v;
  logic [15:0] snap_s;
  logic [7:0]  snap_it;
  logic        ser_valid;
  logic        ser_ready;
  logic        ser_stop;
  logic [7:0]  ser_data;
  // bytes 17..20 and 25..28 share the same nibble offset modulo 4, so one k serves both vector fields
  function automatic logic [7:0] frame_byte(input logic [4:0] i, input logic [63:0] m,
                                            input logic [15:0] v, input logic [15:0] s,
                                            input logic [7:0] it);
    logic [4:0] k;
    k = i - 5'd17;
    return i < 5'd16 ? hex_ascii(m[{i[3:0], 2'b00} +: 4])
         : (i == 5'd16 || i == 5'd21) ? ASCII_SP
         : i < 5'd21 ? hex_ascii(v[{k[1:0], 2'b00} +: 4])
         : i == 5'd22 ? hex_ascii(it[7:4])
         : i == 5'd23 ? hex_ascii(it[3:0])
`ifdef EIGEN_TX_SEED_EN
         : i == 5'd24 ? ASCII_SP
         : i < 5'd29 ? hex_ascii(s[{k[1:0], 2'b00} +: 4])
`endif
         : i == LAST - 5'd2 ? ASCII_CR : ASCII_LF;
  endfunction
  // byte 0 goes out on the start edge itself, so it is taken from the live inputs being snapshotted
  assign ser_valid = (state == IDLE && start && !frame_done) || (state == LOAD && idx != LAST);
  assign ser_data  = frame_byte(idx, state == IDLE ? matrix_a : snap_m, snap_v, snap_s, snap_it);
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk   (clk),
    .reset (reset),
    .valid (ser_valid),
    .data  (ser_data),
    .ready (ser_ready),
    .stop  (ser_stop),
    .txd   (uart_txd)
  );
  // frame sequencer: LOAD covers the stop bit so the next byte is handed over as that stop bit ends
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      snap_m     <= '0;
      snap_v     <= '0;
      snap_s     <= '0;
      snap_it    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE && ser_valid) begin
        snap_m  <= matrix_a;
        snap_v  <= v_new;
        snap_s  <= vector_v;
        snap_it <= iteration_count;
        idx     <= 5'd1;
        busy    <= 1'b1;
        state   <= SEND;
      end else if (state == SEND && ser_stop) begin
        state <= LOAD;
      end else if (state == LOAD && ser_ready) begin
        if (idx == LAST) begin
          state      <= IDLE;
          idx        <= '0;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          idx   <= idx + 5'd1;
          state <= SEND;
        end
      end
    end
  end
endmodule

// File: tb/tb_eigen_uart_tx.sv
// tb_eigen_uart_tx: randomized bench checking the UART line against a bit-stream model every cycle
module tb_eigen_uart_tx;
  localparam int CPB = 16;
`ifdef EIGEN_TX_SEED_EN
  localparam int NBYTES = 31;
`else
  localparam int NBYTES = 26;
`endif
  localparam int FRAME_CYC = NBYTES * 10 * CPB;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, rst_n = 0, start = 0;
  logic [63:0] matrix_a = '0;
  logic [15:0] vector_v = '0, v_new = '0;
  logic [7:0]  iteration_count = '0;
  logic uart_txd, busy, frame_done;
  int checks = 0, failures = 0;
  logic q[$];
  bit m_done = 0, was_done = 0, cmp_en = 0;
  string hx = "0123456789ABCDEF";
  string s1;
  bq_t f;
  int n, errs;

  eigen_uart_tx #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk(clk), .reset(rst_n), .start(start), .matrix_a(matrix_a), .vector_v(vector_v),
    .v_new(v_new), .iteration_count(iteration_count), .uart_txd(uart_txd), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bq_t make_frame(input logic [63:0] m, input logic [15:0] v,
                                     input logic [15:0] s, input logic [7:0] it);
    bq_t b;
    for (int i = 0; i < 16; i++) b.push_back(hx[m[i*4 +: 4]]);
    b.push_back(8'h20);
    for (int i = 0; i < 4; i++) b.push_back(hx[v[i*4 +: 4]]);
    b.push_back(8'h20);
    b.push_back(hx[it[7:4]]);
    b.push_back(hx[it[3:0]]);
`ifdef EIGEN_TX_SEED_EN
    b.push_back(8'h20);
    for (int i = 0; i < 4; i++) b.push_back(hx[s[i*4 +: 4]]);
`endif
    b.push_back(8'h0D);
    b.push_back(8'h0A);
    return b;
  endfunction

  task automatic push_bits(input bq_t b);
    foreach (b[k]) begin
      repeat (CPB) q.push_back(1'b0);
      for (int j = 0; j < 8; j++) repeat (CPB) q.push_back(b[k][j]);
      repeat (CPB) q.push_back(1'b1);
    end
  endtask

  // model: one queue entry per clock of expected line level; empty queue means idle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_done = 0;
    end else begin
      was_done = m_done;
      m_done = 0;
      if (q.size() > 0) begin
        void'(q.pop_front());
        m_done = (q.size() == 0);
      end else if (start && !was_done) begin
        push_bits(make_frame(matrix_a, v_new, vector_v, iteration_count));
      end
    end
  end

  always @(negedge clk) if (cmp_en) begin
    chk("txd", uart_txd, q.size() > 0 ? q[0] : 1'b1);
    chk("busy", busy, q.size() > 0);
    chk("frame_done", frame_done, m_done);
  end

  task automatic randomize_inputs();
    matrix_a = {$urandom, $urandom};
    vector_v = 16'($urandom);
    v_new = 16'($urandom);
    iteration_count = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_done(input string name, input int n0);
    int c;
    c = n0;
    while (!frame_done && c < FRAME_CYC + 1000) begin
      @(negedge clk);
      c++;
    end
    chk(name, c, FRAME_CYC);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    rst_n = 1;
    cmp_en = 1;
    repeat (4) @(negedge clk);
    // diagonal 4, off-diagonal 1
    for (int i = 0; i < 16; i++) matrix_a[i*4 +: 4] = (i / 4 == i % 4) ? 4'h4 : 4'h1;
    v_new = 16'h1111;
    vector_v = 16'h1111;
    iteration_count = 8'h07;
`ifdef EIGEN_TX_SEED_EN
    s1 = "4111141111411114 1111 07 1111\r\n";
`else
    s1 = "4111141111411114 1111 07\r\n";
`endif
    f = make_frame(matrix_a, v_new, vector_v, iteration_count);
    chk("t1_len", f.size(), s1.len());
    errs = 0;
    foreach (f[k]) if (k < s1.len() && f[k] != s1[k]) errs++;
    chk("t1_bytes", errs, 0);
    pulse_start();
    chk("t1_startbit", uart_txd, 0);
    chk("t1_busy", busy, 1);
    repeat (48) @(negedge clk);
    chk("t1_bit2", uart_txd, 1);
    wait_done("t1_cycles", 48);
    repeat (5) @(negedge clk);
    // all-F matrix, AB iteration count
    randomize_inputs();
    matrix_a = '1;
    iteration_count = 8'hAB;
    f = make_frame(matrix_a, v_new, vector_v, iteration_count);
    errs = 0;
    for (int k = 0; k < 16; k++) if (f[k] != 8'h46) errs++;
    chk("t2_matrix_F", errs, 0);
    chk("t2_it_hi", f[22], 8'h41);
    chk("t2_it_lo", f[23], 8'h42);
    pulse_start();
    wait_done("t2_cycles", 0);
    repeat (3) @(negedge clk);
    // start pulses during the frame and on the frame_done cycle
    randomize_inputs();
    pulse_start();
    n = 0;
    while (!frame_done && n < FRAME_CYC + 1000) begin
      @(negedge clk);
      n++;
      start = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) randomize_inputs();
    end
    chk("t3_cycles", n, FRAME_CYC);
    start = 1;
    @(negedge clk) start = 0;
    repeat (300) @(negedge clk);
    chk("t3_idle_busy", busy, 0);
    // inputs change after byte 2
    randomize_inputs();
    pulse_start();
    repeat (3 * 10 * CPB) @(negedge clk);
    randomize_inputs();
    wait_done("t4_cycles", 3 * 10 * CPB);
    repeat (7) @(negedge clk);
    // reset mid-bit during byte 5
    randomize_inputs();
    pulse_start();
    repeat (5 * 10 * CPB + 70) @(negedge clk);
    #3 rst_n = 0;
    #1;
    chk("t5_rst_txd", uart_txd, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", frame_done, 0);
    @(negedge clk) rst_n = 1;
    repeat (200) @(negedge clk);
    randomize_inputs();
    pulse_start();
    wait_done("t5_cycles", 0);
    repeat (2) begin
      repeat ($urandom_range(2, 20)) @(negedge clk);
      randomize_inputs();
      pulse_start();
      wait_done("rand_cycles", 0);
    end
    repeat (20) @(negedge clk);
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
